// File: rtl/ps2_digit_pkg.sv
// rtl/ps2_digit_pkg.sv - shared scancodes, entry states and key decode for ps2_digit_accumulator
package ps2_digit_pkg;

   localparam int BCD_W = 4;
   localparam int NUM_W = 32;

   localparam logic [7:0] SC_0     = 8'h45;
   localparam logic [7:0] SC_1     = 8'h16;
   localparam logic [7:0] SC_2     = 8'h1E;
   localparam logic [7:0] SC_3     = 8'h26;
   localparam logic [7:0] SC_4     = 8'h25;
   localparam logic [7:0] SC_5     = 8'h2E;
   localparam logic [7:0] SC_6     = 8'h36;
   localparam logic [7:0] SC_7     = 8'h3D;
   localparam logic [7:0] SC_8     = 8'h3E;
   localparam logic [7:0] SC_9     = 8'h46;
   localparam logic [7:0] SC_ENTER = 8'h5A;
   localparam logic [7:0] SC_BKSP  = 8'h66;
   localparam logic [7:0] SC_ESC   = 8'h76;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONVERT = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

   typedef struct packed {
      logic             hit;
      logic [BCD_W-1:0] val;
   } key_digit_t;

   function automatic key_digit_t decode_digit(input logic [7:0] sc);
      key_digit_t r;
      r.hit = 1'b1;
      r.val = '0;
      case (sc)
         SC_0:    r.val = 4'd0;
         SC_1:    r.val = 4'd1;
         SC_2:    r.val = 4'd2;
         SC_3:    r.val = 4'd3;
         SC_4:    r.val = 4'd4;
         SC_5:    r.val = 4'd5;
         SC_6:    r.val = 4'd6;
         SC_7:    r.val = 4'd7;
         SC_8:    r.val = 4'd8;
         SC_9:    r.val = 4'd9;
         default: r.hit = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/bcd8_to_bin_serial.sv
// rtl/bcd8_to_bin_serial.sv - serial 8-digit BCD to binary, one digit per cycle, msd first
module bcd8_to_bin_serial
   import ps2_digit_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [7:0][BCD_W-1:0]       bcd,
   output logic                        done,
   output logic [NUM_W-1:0]            result,
   output logic                        busy
);

   logic [NUM_W-1:0] acc;
   logic [2:0]       idx;
   logic [NUM_W-1:0] acc_next;

   // acc*10 as two shifts; the final sum is presented on result during the done cycle
   assign acc_next = (acc << 3) + (acc << 1) + NUM_W'(bcd[idx]);
   assign done     = busy && (idx == 3'd0);
   assign result   = acc_next;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc  <= '0;
         idx  <= '0;
         busy <= 1'b0;
      end else if (start) begin
         acc  <= '0;
         idx  <= 3'd7;
         busy <= 1'b1;
      end else if (busy) begin
         acc <= acc_next;
         idx <= idx - 3'd1;
         if (idx == 3'd0)
            busy <= 1'b0;
      end
   end

endmodule

// File: rtl/ps2_digit_accumulator.sv
// rtl/ps2_digit_accumulator.sv - PS2 keypad digit entry, backspace and Enter-to-binary for CPU MMIO
// Optional Esc clear key: define PS2_DIGIT_CLEAR_KEY_EN.
module ps2_digit_accumulator
   import ps2_digit_pkg::*;
#(
   parameter int MAX_DIGITS = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       scancode,
   input  logic             key_pressed,
   input  logic             cpu_read_ack,
   output logic [NUM_W-1:0] number,
   output logic             number_valid,
   output logic [BCD_W-1:0] digit0,
   output logic [BCD_W-1:0] digit1,
   output logic [BCD_W-1:0] digit2,
   output logic [BCD_W-1:0] digit3,
   output logic [BCD_W-1:0] digit4,
   output logic [BCD_W-1:0] digit5,
   output logic [BCD_W-1:0] digit6,
   output logic [BCD_W-1:0] digit7,
   output logic [3:0]       digit_count,
   output logic             busy
);

   localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

   state_t                  state;
   logic [7:0][BCD_W-1:0]   digits;
   logic [3:0]              count;
   logic                    start_q;
   key_digit_t              kd;
   logic                    conv_done;
   logic [NUM_W-1:0]        conv_result;
   logic                    conv_busy;

   assign kd = decode_digit(scancode);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= ST_IDLE;
         digits       <= '0;
         count        <= '0;
         number       <= '0;
         number_valid <= 1'b0;
         start_q      <= 1'b0;
      end else begin
         start_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (key_pressed) begin
                  if (kd.hit) begin
                     if (count < MAX_CNT) begin
                        digits <= {digits[6:0], kd.val};
                        count  <= count + 4'd1;
                     end
                  end else if (scancode == SC_BKSP) begin
                     if (count != 4'd0) begin
                        digits <= {BCD_W'(0), digits[7:1]};
                        count  <= count - 4'd1;
                     end
                  end else if (scancode == SC_ENTER) begin
                     if (count != 4'd0) begin
                        state   <= ST_CONVERT;
                        start_q <= 1'b1;
                     end
`ifdef PS2_DIGIT_CLEAR_KEY_EN
                  end else if (scancode == SC_ESC) begin
                     digits       <= '0;
                     count        <= '0;
                     number_valid <= 1'b0;
`endif
                  end
               end
            end
            ST_CONVERT: begin
               // keys are swallowed here; digits stay frozen for the converter
               if (conv_done) begin
                  number       <= conv_result;
                  number_valid <= 1'b1;
                  state        <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (cpu_read_ack) begin
                  digits       <= '0;
                  count        <= '0;
                  number_valid <= 1'b0;
                  state        <= ST_IDLE;
               end else if (key_pressed && kd.hit) begin
                  digits       <= {28'd0, kd.val};
                  count        <= 4'd1;
                  number_valid <= 1'b0;
                  state        <= ST_IDLE;
`ifdef PS2_DIGIT_CLEAR_KEY_EN
               end else if (key_pressed && scancode == SC_ESC) begin
                  digits       <= '0;
                  count        <= '0;
                  number_valid <= 1'b0;
                  state        <= ST_IDLE;
`endif
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   bcd8_to_bin_serial u_conv (
      .clk    (clk),
      .rst    (rst),
      .start  (start_q),
      .bcd    (digits),
      .done   (conv_done),
      .result (conv_result),
      .busy   (conv_busy)
   );

   assign busy        = conv_busy;
   assign digit_count = count;
   assign digit0      = digits[0];
   assign digit1      = digits[1];
   assign digit2      = digits[2];
   assign digit3      = digits[3];
   assign digit4      = digits[4];
   assign digit5      = digits[5];
   assign digit6      = digits[6];
   assign digit7      = digits[7];

endmodule

// File: doc/ps2_digit_accumulator.md
Name: ps2_digit_accumulator

Overview:
- Sits between the PS2 keyboard controller (scancode plus a one-cycle make strobe) and the CPU MMIO number port and 7-segment digit path.
- Collects up to MAX_DIGITS decimal keystrokes into a BCD shift buffer and supports Backspace.
- On Enter, converts the BCD buffer to binary serially with a multiply-by-10 accumulate.
- Holds number/number_valid until the CPU acknowledges.

Parameters:
- MAX_DIGITS, 8, maximum digits accepted (legal range 1..8; digit ports are always 8 wide).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  reset, asynchronous, active-low.
- scancode  in  8  PS2 set-2 make code; valid only when key_pressed=1.
- key_pressed  in  1  one-cycle strobe per make event; break codes are filtered upstream.
- cpu_read_ack  in  1  one-cycle pulse; CPU has consumed number.
- number  out  32  binary value of the last committed entry.
- number_valid  out  1  high from conversion completion until ack or new entry.
- digit0..digit7  out  4 each  BCD buffer; digit0 = ones place.
- digit_count  out  4  digits currently held, 0..MAX_DIGITS.
- busy  out  1  high while in CONVERT.

Behaviour:
- Reset (async, rst=0): all digits=0, digit_count=0, number=0, number_valid=0, busy=0, state=IDLE. Applies mid-conversion too; the partial accumulator is discarded.
- Key decode (make codes only):
  - 0=0x45, 1=0x16, 2=0x1E, 3=0x26, 4=0x25, 5=0x2E, 6=0x36, 7=0x3D, 8=0x3E, 9=0x46.
  - Enter=0x5A, Backspace=0x66.
  - All other codes are ignored.
- States: IDLE (entry), CONVERT, DONE.
- IDLE, digit key:
  - If digit_count < MAX_DIGITS: shift left (digit7<=digit6 ... digit1<=digit0, digit0<=key), count+1.
  - If full: key dropped, no change.
  - Leading 0 keys are accepted and counted.
- IDLE, Backspace:
  - If count > 0: shift right (digit0<=digit1 ... digit7<=0), count-1.
  - If count = 0: ignored.
- IDLE, Enter:
  - If count = 0: ignored, stays IDLE.
  - Otherwise: go to CONVERT, acc<=0, idx<=7, busy=1.
- CONVERT:
  - One digit per cycle, digit7 down to digit0, always 8 iterations (upper digits are 0).
  - acc <= (acc<<3) + (acc<<1) + digit[idx], 32-bit arithmetic. Maximum is 99,999,999, which fits in 27 bits, so no overflow.
  - Every key_pressed is ignored (dropped) while busy.
- Latency: Enter sampled at edge k -> number valid and number_valid=1 at edge k+9. busy=1 for edges k+1..k+8, 0 at k+9. State = DONE.
- DONE:
  - number and number_valid are held; digits are held so the display shows the entry.
  - cpu_read_ack: digits<=0, count<=0, number_valid<=0, go to IDLE. number keeps its last value.
  - Digit key (no ack): clear buffer, load the key as digit0, count=1, number_valid<=0, go to IDLE.
  - Backspace or Enter in DONE: ignored.
  - ack and key in the same cycle: ack wins, key dropped.
- cpu_read_ack outside DONE: no effect.
- digit_count never exceeds MAX_DIGITS and never wraps below 0.

Optional Feature:
- Macro: PS2_DIGIT_CLEAR_KEY_EN.
- Defined: Esc (0x76) in IDLE or DONE clears digits and count and drops number_valid; it takes effect the next cycle and the state goes to IDLE. Esc is ignored during CONVERT. In DONE, ack has priority over Esc.
- Undefined: 0x76 is treated like any unknown code (ignored).

Decomposition:
- Shared package ps2_digit_pkg:
  - scancode constants (SC_0..SC_9, SC_ENTER, SC_BKSP, SC_ESC);
  - 2-bit state encoding (ST_IDLE, ST_CONVERT, ST_DONE);
  - BCD_W=4, NUM_W=32.
- Natural sub-module: bcd8_to_bin_serial.
  - Inputs: start pulse, 8x4 BCD.
  - Outputs: done, 32-bit result, busy.
  - Owns acc/idx and the shift-add multiply-by-10.
- Top of the block keeps the entry FSM, key decode and buffer.

Test Plan:
- Keys 1,2,3, Enter at edge k -> busy edges k+1..k+8; number=123 (0x0000007B) and number_valid=1 at k+9; digit2..0=1,2,3; count=3.
- Keys 1,2,3, Backspace, 4, Enter -> number=124. A Backspace with count=0 leaves the buffer all-zero, count=0.
- Keys 1..9 then Enter (MAX_DIGITS=8) -> 9 dropped; digit7..0=1..8; number=12345678 (0x00BC614E).
- Enter with empty buffer -> state stays IDLE, busy never asserts, number_valid stays 0. Then key 5 during CONVERT of a prior entry -> dropped.
- In DONE, cpu_read_ack together with key 7 -> number_valid=0, digits all 0, count=0, key 7 not loaded. Key 7 alone in DONE -> digit0=7, count=1, number_valid=0.
- Assert rst low at edge k+4 of a conversion -> all outputs 0 immediately (async). After release, keys 4, 2, Enter -> number=42.
